// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Contents: operand width, opcode and FSM state enums, the MIPS FUNCT codes
// that map onto the opcodes, and small helpers used by decode and the
// sequencer.
package muldiv_sequencer_pkg;

  localparam int MD_WIDTH = 32;

  // MIPS SPECIAL-opcode FUNCT field values for the HI/LO-writing ops
  localparam logic [5:0] FUNC_MTHI  = 6'h11;
  localparam logic [5:0] FUNC_MTLO  = 6'h13;
  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_NOP   = 3'd7
  } muldiv_op_t;

  // The divide state is MD_DIVIDE because MD_DIV is already the opcode.
  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_MUL    = 2'd1,
    MD_DIVIDE = 2'd2,
    MD_FIX    = 2'd3
  } muldiv_state_t;

  function automatic muldiv_op_t decode_func(input logic [5:0] func);
    case (func)
      FUNC_MULT:  decode_func = MD_MULT;
      FUNC_MULTU: decode_func = MD_MULTU;
      FUNC_DIV:   decode_func = MD_DIV;
      FUNC_DIVU:  decode_func = MD_DIVU;
      FUNC_MTHI:  decode_func = MD_MTHI;
      FUNC_MTLO:  decode_func = MD_MTLO;
      default:    decode_func = MD_NOP;
    endcase
  endfunction

  // Absolute value for signed ops; 0x80000000 stays 0x80000000, which is
  // the correct unsigned magnitude.
  function automatic logic [MD_WIDTH-1:0] magnitude(input logic [MD_WIDTH-1:0] v,
                                                    input logic is_signed);
    magnitude = (is_signed && v[MD_WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between the execute stage (master) and the
// multiply/divide sequencer (slave).
//   start_i, op_i, rs_i, rt_i, mf_read_i : core -> sequencer
//   busy_o, stall_o, done_o, mfhi_o, mflo_o : sequencer -> core
interface muldiv_sequencer_if;
  import muldiv_sequencer_pkg::*;

  logic                start_i;
  muldiv_op_t          op_i;
  logic [MD_WIDTH-1:0] rs_i;
  logic [MD_WIDTH-1:0] rt_i;
  logic                mf_read_i;
  logic                busy_o;
  logic                stall_o;
  logic                done_o;
  logic [MD_WIDTH-1:0] mfhi_o;
  logic [MD_WIDTH-1:0] mflo_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, mf_read_i,
    input  busy_o, stall_o, done_o, mfhi_o, mflo_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, mf_read_i,
    output busy_o, stall_o, done_o, mfhi_o, mflo_o
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the unsigned multiply or divide.
//   div_mode_i : 0 = shift-add multiply step, 1 = restoring divide step
//   hi_i/lo_i  : multiply: product upper/lower half (lower half starts as
//                the multiplier); divide: partial remainder / dividend bits
//                shifting out while quotient bits shift in
//   operand_i  : multiplicand or divisor
//   hi_o/lo_o  : the same pair after one step
module muldiv_step
  import muldiv_sequencer_pkg::*;
(
  input  logic                div_mode_i,
  input  logic [MD_WIDTH-1:0] hi_i,
  input  logic [MD_WIDTH-1:0] lo_i,
  input  logic [MD_WIDTH-1:0] operand_i,
  output logic [MD_WIDTH-1:0] hi_o,
  output logic [MD_WIDTH-1:0] lo_o
);

  logic [MD_WIDTH:0] sum;
  logic [MD_WIDTH:0] shifted;
  logic [MD_WIDTH:0] diff;

  always_comb begin
    // Carry out of the add becomes the new product MSB after the shift.
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : {(MD_WIDTH+1){1'b0}});
    shifted = {hi_i, lo_i[MD_WIDTH-1]};
    diff    = shifted - {1'b0, operand_i};
    if (div_mode_i) begin
      // Remainder stays below the divisor, so diff[MD_WIDTH] is a clean
      // borrow flag and the restored value always fits in MD_WIDTH bits.
      if (!diff[MD_WIDTH]) begin
        hi_o = diff[MD_WIDTH-1:0];
        lo_o = {lo_i[MD_WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shifted[MD_WIDTH-1:0];
        lo_o = {lo_i[MD_WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[MD_WIDTH:1];
      lo_o = {sum[0], lo_i[MD_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
//   clk, reset_i : clock, asynchronous active-high reset
//   bus (slave)  : start_i/op_i/rs_i/rt_i/mf_read_i in,
//                  busy_o/stall_o/done_o/mfhi_o/mflo_o out
// UNROLL (1, 2, 4, 8) muldiv_step copies run per clock, so an op spends
// 32/UNROLL edges iterating plus one FIX edge for sign correction.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input logic               clk,
  input logic               reset_i,
  muldiv_sequencer_if.slave bus
);

  localparam int N     = MD_WIDTH / UNROLL;
  localparam int CNT_W = $clog2(N) + 1;

  muldiv_state_t       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MD_WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [MD_WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [MD_WIDTH-1:0] operand_q, operand_d;
  logic                is_div_q, is_div_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic [MD_WIDTH-1:0] hi_q, hi_d;
  logic [MD_WIDTH-1:0] lo_q, lo_d;
  logic                done_q, done_d;

  logic [MD_WIDTH-1:0] chain_hi [UNROLL+1];
  logic [MD_WIDTH-1:0] chain_lo [UNROLL+1];

  assign chain_hi[0] = acc_hi_q;
  assign chain_lo[0] = acc_lo_q;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
      muldiv_step u_step (
        .div_mode_i (is_div_q),
        .hi_i       (chain_hi[gi]),
        .lo_i       (chain_lo[gi]),
        .operand_i  (operand_q),
        .hi_o       (chain_hi[gi+1]),
        .lo_o       (chain_lo[gi+1])
      );
    end
  endgenerate

  logic                  signed_op;
  logic                  sign_xor;
  logic [MD_WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*MD_WIDTH-1:0] prod, prod_fix;

  assign signed_op = (bus.op_i == MD_MULT) || (bus.op_i == MD_DIV);
  assign sign_xor  = signed_op & (bus.rs_i[MD_WIDTH-1] ^ bus.rt_i[MD_WIDTH-1]);
  assign rs_mag    = magnitude(bus.rs_i, signed_op);
  assign rt_mag    = magnitude(bus.rt_i, signed_op);
  assign prod      = {acc_hi_q, acc_lo_q};
  assign prod_fix  = qneg_q ? (~prod + 1'b1) : prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    operand_d = operand_q;
    is_div_d  = is_div_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (bus.start_i) begin
          case (bus.op_i)
            MD_MTHI: hi_d = bus.rs_i;
            MD_MTLO: lo_d = bus.rs_i;
            MD_MULT, MD_MULTU: begin
              acc_hi_d  = '0;
              acc_lo_d  = rt_mag;   // multiplier bits are consumed from the LSB
              operand_d = rs_mag;
              is_div_d  = 1'b0;
              qneg_d    = sign_xor;
              rneg_d    = 1'b0;
              cnt_d     = CNT_W'(N);
              state_d   = MD_MUL;
            end
            MD_DIV, MD_DIVU: begin
              if (bus.rt_i == '0) begin
                hi_d   = '0;
                lo_d   = '0;
                done_d = 1'b1;
              end else begin
                acc_hi_d  = '0;
                acc_lo_d  = rs_mag; // dividend bits are consumed from the MSB
                operand_d = rt_mag;
                is_div_d  = 1'b1;
                qneg_d    = sign_xor;
                rneg_d    = signed_op & bus.rs_i[MD_WIDTH-1];
                cnt_d     = CNT_W'(N);
                state_d   = MD_DIVIDE;
              end
            end
            default: ;
          endcase
        end
      end
      MD_MUL, MD_DIVIDE: begin
        acc_hi_d = chain_hi[UNROLL];
        acc_lo_d = chain_lo[UNROLL];
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        if (is_div_q) begin
          lo_d = qneg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
          hi_d = rneg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      operand_q <= operand_d;
      is_div_q  <= is_div_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy_o  = (state_q != MD_IDLE);
  assign bus.stall_o = bus.busy_o & (bus.mf_read_i | bus.start_i);
  assign bus.done_o  = done_q;
  assign bus.mfhi_o  = hi_q;
  assign bus.mflo_o  = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: one sequencer with UNROLL=1 and one with UNROLL=4
// share stimulus registers; sel picks which one receives start/mf_read and
// which one is observed. Expected HI/LO come from plain 64-bit arithmetic.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        start_r = 1'b0;
  logic        mf_r = 1'b0;
  muldiv_op_t  op_r = MD_NOP;
  logic [31:0] rs_r = '0;
  logic [31:0] rt_r = '0;

  always #5 clk = ~clk;

  muldiv_sequencer_if bus1 ();
  muldiv_sequencer_if bus4 ();

  assign bus1.start_i   = start_r & ~sel;
  assign bus1.mf_read_i = mf_r & ~sel;
  assign bus1.op_i      = op_r;
  assign bus1.rs_i      = rs_r;
  assign bus1.rt_i      = rt_r;
  assign bus4.start_i   = start_r & sel;
  assign bus4.mf_read_i = mf_r & sel;
  assign bus4.op_i      = op_r;
  assign bus4.rs_i      = rs_r;
  assign bus4.rt_i      = rt_r;

  muldiv_sequencer #(.UNROLL(1)) u_dut1 (.clk(clk), .reset_i(reset), .bus(bus1.slave));
  muldiv_sequencer #(.UNROLL(4)) u_dut4 (.clk(clk), .reset_i(reset), .bus(bus4.slave));

  logic        busy_w, stall_w, done_w;
  logic [31:0] hi_w, lo_w;
  assign busy_w  = sel ? bus4.busy_o  : bus1.busy_o;
  assign stall_w = sel ? bus4.stall_o : bus1.stall_o;
  assign done_w  = sel ? bus4.done_o  : bus1.done_o;
  assign hi_w    = sel ? bus4.mfhi_o  : bus1.mfhi_o;
  assign lo_w    = sel ? bus4.mflo_o  : bus1.mflo_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] ref_hi [2];
  logic [31:0] ref_lo [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s (unroll=%0d): got %h expected %h", tag, sel ? 4 : 1, got, exp);
    end
  endtask

  // Architectural result of one op on HI/LO.
  function automatic void model(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] nhi, output logic [31:0] nlo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    nhi = hi;
    nlo = lo;
    case (op)
      MD_MULT:  begin p = sa * sb; nhi = p[63:32]; nlo = p[31:0]; end
      MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; nhi = p[63:32]; nlo = p[31:0]; end
      MD_DIV, MD_DIVU: begin
        if (b == 0) begin
          nhi = '0; nlo = '0;
        end else begin
          if (op == MD_DIVU) begin sa = longint'({32'd0, a}); sb = longint'({32'd0, b}); end
          q = sa / sb;
          r = sa % sb;
          nlo = q[31:0];
          nhi = r[31:0];
        end
      end
      MD_MTHI: nhi = a;
      MD_MTLO: nlo = a;
      default: ;
    endcase
  endfunction

  // Called right after the accept edge; counts edges until done_o.
  task automatic wait_done(input logic [31:0] old_hi, input logic [31:0] old_lo,
                           output int lat, output int bcyc);
    lat = 0;
    bcyc = 0;
    while (!done_w && lat < 200) begin
      if (busy_w) bcyc++;
      if (lat == 2) begin
        check("hold_hi", hi_w, old_hi);
        check("hold_lo", lo_w, old_lo);
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    int          idx, lat, bc, n_it;
    logic        is_div;
    idx    = sel ? 1 : 0;
    n_it   = sel ? 9 : 33;
    is_div = (op == MD_DIV) || (op == MD_DIVU);
    model(op, a, b, ref_hi[idx], ref_lo[idx], nh, nl);
    @(negedge clk);
    start_r = 1'b1; op_r = op; rs_r = a; rt_r = b;
    @(posedge clk); #1;
    start_r = 1'b0;
    if (op == MD_MTHI || op == MD_MTLO || op == MD_NOP || (is_div && b == 0)) begin
      check("imm_busy", busy_w, 0);
      check("imm_done", done_w, is_div);
      check("imm_hi", hi_w, nh);
      check("imm_lo", lo_w, nl);
      @(posedge clk); #1;
      check("imm_done_clr", done_w, 0);
    end else begin
      check("accept_busy", busy_w, 1);
      wait_done(ref_hi[idx], ref_lo[idx], lat, bc);
      check("latency", lat, n_it);
      check("busy_cycles", bc, n_it);
      check("hi", hi_w, nh);
      check("lo", lo_w, nl);
      @(posedge clk); #1;
      check("done_pulse", done_w, 0);
      check("idle_busy", busy_w, 0);
    end
    ref_hi[idx] = nh;
    ref_lo[idx] = nl;
    $display("unroll=%0d op=%s rs=%h rt=%h -> hi=%h lo=%h", sel ? 4 : 1, op.name(), a, b, hi_w, lo_w);
  endtask

  logic [5:0] funcs [6];

  initial begin
    logic [31:0] a, b, nh, nl;
    int          lat, bc;
    muldiv_op_t  op;

    funcs = '{FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU, FUNC_MTHI, FUNC_MTLO};
    ref_hi = '{32'd0, 32'd0};
    ref_lo = '{32'd0, 32'd0};

    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      check("rst_hi", hi_w, 0);
      check("rst_lo", lo_w, 0);
      check("rst_busy", busy_w, 0);
      check("rst_done", done_w, 0);
    end

    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      check("multu_max_hi", hi_w, 32'hFFFFFFFE);
      check("multu_max_lo", lo_w, 32'h00000001);
      run_op(MD_MULT, 32'hFFFFFFFD, 32'd7);
      run_op(MD_MULT, 32'h80000000, 32'h80000000);
      check("mult_min_hi", hi_w, 32'h40000000);
      run_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
      run_op(MD_DIVU, 32'd7, 32'd2);
      run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      check("div_ovf_lo", lo_w, 32'h80000000);
      run_op(MD_DIVU, 32'd5, 32'd0);

      // MTHI then MTLO on back-to-back edges
      @(negedge clk);
      start_r = 1'b1; op_r = MD_MTHI; rs_r = 32'h12345678;
      @(posedge clk); #1;
      check("mthi_hi", hi_w, 32'h12345678);
      check("mthi_lo", lo_w, 0);
      check("mthi_done", done_w, 0);
      @(negedge clk);
      op_r = MD_MTLO; rs_r = 32'h9ABCDEF0;
      @(posedge clk); #1;
      start_r = 1'b0;
      check("mtlo_lo", lo_w, 32'h9ABCDEF0);
      check("mtlo_hi", hi_w, 32'h12345678);
      check("mtlo_done", done_w, 0);
      ref_hi[s] = 32'h12345678;
      ref_lo[s] = 32'h9ABCDEF0;
      $display("unroll=%0d op=MTHI/MTLO -> hi=%h lo=%h", sel ? 4 : 1, hi_w, lo_w);

      for (int i = 0; i < 15; i++) begin
        op = decode_func(funcs[$urandom_range(0, 5)]);
        a  = $urandom;
        case ($urandom_range(0, 7))
          0:       b = 32'd0;
          1:       b = $urandom_range(1, 15);
          2:       b = 32'hFFFFFFFF;
          default: b = $urandom;
        endcase
        run_op(op, a, b);
      end
    end

    // Stall: MFHI and a second start presented while MULT runs.
    sel = 1'b0;
    a = $urandom;
    b = $urandom;
    model(MD_MULT, a, b, ref_hi[0], ref_lo[0], nh, nl);
    @(negedge clk);
    start_r = 1'b1; op_r = MD_MULT; rs_r = a; rt_r = b;
    @(posedge clk); #1;
    @(negedge clk);
    op_r = MD_DIVU; rs_r = 32'd9; rt_r = 32'd4; mf_r = 1'b1;
    lat = 0;
    while (busy_w && lat < 100) begin
      check("stall_busy", stall_w, 1);
      @(posedge clk); #1;
      lat++;
    end
    check("stall_wait", lat, 33);
    check("stall_done", done_w, 1);
    check("stall_clear", stall_w, 0);
    check("stall_mult_hi", hi_w, nh);
    check("stall_mult_lo", lo_w, nl);
    $display("unroll=1 op=MULT rs=%h rt=%h -> hi=%h lo=%h (under stall)", a, b, hi_w, lo_w);
    ref_hi[0] = nh;
    ref_lo[0] = nl;
    @(posedge clk); #1;
    start_r = 1'b0;
    mf_r = 1'b0;
    check("queued_accept", busy_w, 1);
    wait_done(ref_hi[0], ref_lo[0], lat, bc);
    check("queued_latency", lat, 33);
    check("queued_lo", lo_w, 32'd2);
    check("queued_hi", hi_w, 32'd1);
    ref_hi[0] = 32'd1;
    ref_lo[0] = 32'd2;
    $display("unroll=1 op=DIVU rs=9 rt=4 -> hi=%h lo=%h (queued)", hi_w, lo_w);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start_r = 1'b1; op_r = MD_DIV; rs_r = 32'd1000; rt_r = 32'd7;
    @(posedge clk); #1;
    start_r = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_hi", hi_w, 0);
    check("async_rst_lo", lo_w, 0);
    check("async_rst_busy", busy_w, 0);
    check("async_rst_done", done_w, 0);
    $display("unroll=1 op=DIV rs=1000 rt=7 abandoned by reset -> hi=%h lo=%h", hi_w, lo_w);
    ref_hi = '{32'd0, 32'd0};
    ref_lo = '{32'd0, 32'd0};
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    run_op(MD_MULTU, 32'd3, 32'd5);
    check("post_rst_lo", lo_w, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
